// File: rtl/hssim_frame_reduce_if.sv
// Stream bundle between HSSIM, the frame reducer and the fusion-weight divider:
// per-pixel numr/denr beats in, one pair of signed frame sums out.
interface hssim_frame_reduce_if #(
    parameter int NUMR_WIDTH = 576,
    parameter int DENR_WIDTH = 576,
    parameter int ACC_WIDTH  = 56,
    parameter int CNT_WIDTH  = 14
);
    logic                  in_valid;
    logic                  in_ready;
    logic [NUMR_WIDTH-1:0] numr_in;
    logic [DENR_WIDTH-1:0] denr_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACC_WIDTH-1:0]  numr_sum;
    logic [ACC_WIDTH-1:0]  denr_sum;
    logic [CNT_WIDTH-1:0]  beat_cnt;

    modport master (
        output in_valid, numr_in, denr_in, out_ready,
        input  in_ready, out_valid, numr_sum, denr_sum, beat_cnt
    );

    modport slave (
        input  in_valid, numr_in, denr_in, out_ready,
        output in_ready, out_valid, numr_sum, denr_sum, beat_cnt
    );
endinterface

// File: rtl/hssim_frame_reduce.sv
// Reduces HSSIM numerator/denominator lane beats to one signed sum pair per
// IMAGE_DIM x IMAGE_DIM frame: lane adder tree (S1), frame accumulator (S2).
module hssim_frame_reduce #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int NUMR_BIT_WIDTH  = 36,
    parameter int DENR_BIT_WIDTH  = 36,
    parameter int NUMR_WIDTH      = NUMR_BIT_WIDTH * PIXELS_PER_BEAT,
    parameter int DENR_WIDTH      = DENR_BIT_WIDTH * PIXELS_PER_BEAT,
    parameter int ACC_WIDTH       = 56
) (
    input logic                clk,
    input logic                aresetn,
    input logic                stall,
    hssim_frame_reduce_if.slave bus
);
    localparam int BEATS     = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int CNT_WIDTH = $clog2(BEATS);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(BEATS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                       state_r;
    state_t                       state_s;
    logic                         accept_s;
    logic                         in_ready_r;
    logic                         out_valid_r;
    logic [CNT_WIDTH-1:0]         beat_cnt_r;
    logic                         s1_valid_r;
    logic signed [ACC_WIDTH-1:0]  s1_numr_r;
    logic signed [ACC_WIDTH-1:0]  s1_denr_r;
    logic signed [ACC_WIDTH-1:0]  acc_numr_r;
    logic signed [ACC_WIDTH-1:0]  acc_denr_r;
    logic signed [ACC_WIDTH-1:0]  numr_sum_r;
    logic signed [ACC_WIDTH-1:0]  denr_sum_r;

    function automatic logic signed [ACC_WIDTH-1:0] sum_numr(input logic [NUMR_WIDTH-1:0] beat);
        logic signed [ACC_WIDTH-1:0] total;
        logic [NUMR_BIT_WIDTH-1:0]   lane;
        total = '0;
        for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
            lane  = beat[i*NUMR_BIT_WIDTH +: NUMR_BIT_WIDTH];
            total = total + {{(ACC_WIDTH-NUMR_BIT_WIDTH){lane[NUMR_BIT_WIDTH-1]}}, lane};
        end
        return total;
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sum_denr(input logic [DENR_WIDTH-1:0] beat);
        logic signed [ACC_WIDTH-1:0] total;
        logic [DENR_BIT_WIDTH-1:0]   lane;
        total = '0;
        for (int i = 0; i < PIXELS_PER_BEAT; i++) begin
            lane  = beat[i*DENR_BIT_WIDTH +: DENR_BIT_WIDTH];
            total = total + {{(ACC_WIDTH-DENR_BIT_WIDTH){lane[DENR_BIT_WIDTH-1]}}, lane};
        end
        return total;
    endfunction

    assign accept_s = bus.in_valid & in_ready_r & ~stall;

    // State register.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state; DRAIN finishes on the first unstalled cycle with S1 empty.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ACCUM: begin
                if (accept_s && (beat_cnt_r == LAST_BEAT)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ACCUM;
                end
            end
            DRAIN: begin
                if (!stall && !s1_valid_r) begin
                    state_s = HOLD;
                end else begin
                    state_s = DRAIN;
                end
            end
            HOLD: begin
                if (out_valid_r && bus.out_ready) begin
                    state_s = ACCUM;
                end else begin
                    state_s = HOLD;
                end
            end
            default: state_s = ACCUM;
        endcase
    end

    // Handshake outputs and beat counter.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            beat_cnt_r  <= '0;
        end else begin
            in_ready_r  <= (state_s == ACCUM);
            out_valid_r <= (state_s == HOLD);
            if (accept_s) begin
                beat_cnt_r <= (beat_cnt_r == LAST_BEAT) ? '0 : beat_cnt_r + CNT_ONE;
            end
        end
    end

    // S1 lane adder tree and S2 accumulators; frame sums latched on DRAIN exit.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            s1_valid_r <= 1'b0;
            s1_numr_r  <= '0;
            s1_denr_r  <= '0;
            acc_numr_r <= '0;
            acc_denr_r <= '0;
            numr_sum_r <= '0;
            denr_sum_r <= '0;
        end else begin
            if (!stall) begin
                s1_valid_r <= accept_s;
                if (accept_s) begin
                    s1_numr_r <= sum_numr(bus.numr_in);
                    s1_denr_r <= sum_denr(bus.denr_in);
                end
            end
            if ((state_r == DRAIN) && (state_s == HOLD)) begin
                numr_sum_r <= acc_numr_r;
                denr_sum_r <= acc_denr_r;
                acc_numr_r <= '0;
                acc_denr_r <= '0;
            end else if (!stall && s1_valid_r) begin
                acc_numr_r <= acc_numr_r + s1_numr_r;
                acc_denr_r <= acc_denr_r + s1_denr_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.numr_sum  = numr_sum_r;
    assign bus.denr_sum  = denr_sum_r;
    assign bus.beat_cnt  = beat_cnt_r;
endmodule

// File: tb/tb_hssim_frame_reduce.sv
// Randomized bench for hssim_frame_reduce: a default-size instance for full
// 512x512 frames and an 8x8 / 4-lane instance for stall, gap and hold cases.
module tb_hssim_frame_reduce;
    logic clk = 1'b0;
    logic aresetn;
    logic b_stall;
    logic s_stall;
    int   n_cmp = 0;
    int   n_bad = 0;

    hssim_frame_reduce_if #(.NUMR_WIDTH(576), .DENR_WIDTH(576), .ACC_WIDTH(56), .CNT_WIDTH(14)) b_bus ();
    hssim_frame_reduce_if #(.NUMR_WIDTH(144), .DENR_WIDTH(144), .ACC_WIDTH(56), .CNT_WIDTH(4))  s_bus ();

    hssim_frame_reduce u_big (
        .clk     (clk),
        .aresetn (aresetn),
        .stall   (b_stall),
        .bus     (b_bus)
    );

    hssim_frame_reduce #(.PIXELS_PER_BEAT(4), .IMAGE_DIM(8)) u_small (
        .clk     (clk),
        .aresetn (aresetn),
        .stall   (s_stall),
        .bus     (s_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sx36(input logic [35:0] v);
        logic signed [35:0] t;
        t = v;
        return longint'(t);
    endfunction

    // Lane value for the small instance: 0 random, 1 beat index, 2 alternating +5/-5.
    function automatic logic [35:0] lane_val(input int mode, input int beat, input int lane);
        logic [63:0] r;
        r = {$urandom, $urandom};
        case (mode)
            1:       return 36'(beat);
            2:       return (lane % 2 == 0) ? 36'sd5 : -36'sd5;
            default: return r[35:0];
        endcase
    endfunction

    task automatic check_reset_outputs(input string who);
        chk({who, "_rst_in_ready"}, b_bus.in_ready, 64'sd1);
        chk({who, "_rst_out_valid"}, b_bus.out_valid, 64'sd0);
        chk({who, "_rst_numr"}, $signed(b_bus.numr_sum), 64'sd0);
        chk({who, "_rst_denr"}, $signed(b_bus.denr_sum), 64'sd0);
        chk({who, "_rst_cnt"}, b_bus.beat_cnt, 64'sd0);
        chk({who, "_s_rst_in_ready"}, s_bus.in_ready, 64'sd1);
        chk({who, "_s_rst_out_valid"}, s_bus.out_valid, 64'sd0);
        chk({who, "_s_rst_cnt"}, s_bus.beat_cnt, 64'sd0);
    endtask

    // Full default frame with constant lanes, optional abort by reset and hold time.
    task automatic big_frame(input logic [35:0] nv, input logic [35:0] dv, input longint en,
                             input longint ed, input int abort_at, input int hold_n);
        for (int b = 0; b < 16384; b++) begin
            @(negedge clk);
            if (b == abort_at) begin
                chk("b_cnt_before_abort", b_bus.beat_cnt, 64'(abort_at));
                b_bus.in_valid = 1'b0;
                aresetn = 1'b0;
                @(negedge clk);
                aresetn = 1'b1;
                check_reset_outputs("abort");
                return;
            end
            b_bus.in_valid = 1'b1;
            b_bus.numr_in  = {16{nv}};
            b_bus.denr_in  = {16{dv}};
        end
        @(negedge clk);
        chk("b_in_ready_drain", b_bus.in_ready, 64'sd0);
        chk("b_out_valid_lat1", b_bus.out_valid, 64'sd0);
        @(negedge clk);
        chk("b_out_valid_lat2", b_bus.out_valid, 64'sd0);
        @(negedge clk);
        b_bus.in_valid = 1'b0;
        chk("b_out_valid", b_bus.out_valid, 64'sd1);
        chk("b_numr_sum", $signed(b_bus.numr_sum), en);
        chk("b_denr_sum", $signed(b_bus.denr_sum), ed);
        chk("b_cnt_wrap", b_bus.beat_cnt, 64'sd0);
        for (int h = 0; h < hold_n; h++) begin
            b_stall = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("b_hold_valid", b_bus.out_valid, 64'sd1);
            chk("b_hold_ready", b_bus.in_ready, 64'sd0);
            chk("b_hold_numr", $signed(b_bus.numr_sum), en);
            chk("b_hold_denr", $signed(b_bus.denr_sum), ed);
        end
        b_stall = 1'b0;
        b_bus.out_ready = 1'b1;
        @(negedge clk);
        b_bus.out_ready = 1'b0;
        chk("b_handoff_valid", b_bus.out_valid, 64'sd0);
        chk("b_handoff_ready", b_bus.in_ready, 64'sd1);
        chk("b_kept_numr", $signed(b_bus.numr_sum), en);
    endtask

    // Small frame with random gaps/stalls; model sums every beat the bench knows was accepted.
    task automatic small_frame(input int mode, input int hold_n, input bit pre_ready);
        longint      en = 0;
        longint      ed = 0;
        int          acc_n = 0;
        int          guard = 0;
        int          unst = 0;
        logic [35:0] nv;
        logic [35:0] dv;
        logic [143:0] nb;
        logic [143:0] db;
        while (acc_n < 16 && guard < 2000) begin
            @(negedge clk);
            guard++;
            chk("s_in_ready", s_bus.in_ready, 64'sd1);
            chk("s_beat_cnt", s_bus.beat_cnt, 64'(acc_n));
            s_bus.out_ready = 1'($urandom_range(0, 1));
            s_stall         = ($urandom_range(0, 3) == 0);
            s_bus.in_valid  = ($urandom_range(0, 3) != 0);
            for (int l = 0; l < 4; l++) begin
                nv = lane_val(mode, acc_n, l);
                dv = lane_val(mode, acc_n, l);
                nb[l*36 +: 36] = nv;
                db[l*36 +: 36] = dv;
                if (s_bus.in_valid && !s_stall) begin
                    en += sx36(nv);
                    ed += sx36(dv);
                end
            end
            s_bus.numr_in = nb;
            s_bus.denr_in = db;
            if (s_bus.in_valid && !s_stall) acc_n++;
        end
        chk("s_accept_budget", 64'(acc_n), 64'sd16);
        guard = 0;
        while (unst < 2 && guard < 200) begin
            @(negedge clk);
            guard++;
            chk("s_drain_valid", s_bus.out_valid, 64'sd0);
            chk("s_drain_ready", s_bus.in_ready, 64'sd0);
            s_stall         = ($urandom_range(0, 2) == 0);
            s_bus.in_valid  = 1'($urandom_range(0, 1));
            s_bus.numr_in   = {$urandom, $urandom, $urandom, $urandom, $urandom};
            s_bus.out_ready = pre_ready;
            if (!s_stall) unst++;
        end
        @(negedge clk);
        chk("s_out_valid", s_bus.out_valid, 64'sd1);
        chk("s_numr_sum", $signed(s_bus.numr_sum), en);
        chk("s_denr_sum", $signed(s_bus.denr_sum), ed);
        chk("s_cnt_wrap", s_bus.beat_cnt, 64'sd0);
        chk("s_hold_ready", s_bus.in_ready, 64'sd0);
        if (!pre_ready) begin
            for (int h = 0; h < hold_n; h++) begin
                s_stall        = 1'($urandom_range(0, 1));
                s_bus.in_valid = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("s_hold_valid", s_bus.out_valid, 64'sd1);
                chk("s_hold_in_ready", s_bus.in_ready, 64'sd0);
                chk("s_hold_numr", $signed(s_bus.numr_sum), en);
                chk("s_hold_denr", $signed(s_bus.denr_sum), ed);
            end
            s_bus.out_ready = 1'b1;
        end
        @(negedge clk);
        chk("s_handoff_valid", s_bus.out_valid, 64'sd0);
        chk("s_handoff_ready", s_bus.in_ready, 64'sd1);
        chk("s_kept_numr", $signed(s_bus.numr_sum), en);
        s_bus.out_ready = 1'b0;
        s_bus.in_valid  = 1'b0;
        s_stall         = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        b_stall = 1'b0;
        s_stall = 1'b0;
        b_bus.in_valid = 1'b0;
        b_bus.out_ready = 1'b0;
        b_bus.numr_in = '0;
        b_bus.denr_in = '0;
        s_bus.in_valid = 1'b0;
        s_bus.out_ready = 1'b0;
        s_bus.numr_in = '0;
        s_bus.denr_in = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("init");
        aresetn = 1'b1;

        big_frame(36'd1, 36'd2, 64'sd262144, 64'sd524288, -1, 0);
        big_frame(36'hF_FFFF_FFFF, 36'h7_FFFF_FFFF, -64'sd262144,
                  64'sd262144 * 64'sd34359738367, -1, 10);
        big_frame(36'd1, 36'd2, 64'sd0, 64'sd0, 100, 0);
        big_frame(36'd1, 36'd2, 64'sd262144, 64'sd524288, -1, 0);

        for (int i = 0; i < 12; i++) begin
            small_frame(i % 3, (i % 4 == 0) ? 10 : 0, (i % 4 == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached with %0d compared", n_cmp);
        $fatal(1);
    end
endmodule

// File: doc/hssim_frame_reduce.md
Name: hssim_frame_reduce

Overview:
- Downstream end of the HSSIM numerator/denominator stream.
- Consumes the per-pixel signed numr/denr lane beats that HSSIM produces under the shared `stall` protocol and reduces them to one signed numerator sum and one signed denominator sum per IMAGE_DIM x IMAGE_DIM frame.
- Presents the frame result on a valid/ready output for the fusion-weight divider.
- Sits directly after HSSIM in the LRF quality-metric path.

Parameters:
- PIXELS_PER_BEAT, 16, lanes per beat.
- IMAGE_DIM, 512, frame width and height in pixels.
- NUMR_BIT_WIDTH, 36, signed width of one numerator lane.
- DENR_BIT_WIDTH, 36, signed width of one denominator lane.
- NUMR_WIDTH, NUMR_BIT_WIDTH*PIXELS_PER_BEAT, packed numerator beat width.
- DENR_WIDTH, DENR_BIT_WIDTH*PIXELS_PER_BEAT, packed denominator beat width.
- ACC_WIDTH, 56, signed accumulator width (must be >= max(NUMR_BIT_WIDTH, DENR_BIT_WIDTH) + clog2(IMAGE_DIM*IMAGE_DIM)).

Ports:
- clk  input  1  system clock.
- aresetn  input  1  reset; one clock; reset is synchronous and active-low.
- stall  input  1  shared pipeline stall; while high, the input and pipeline stages hold.
- in_valid  input  1  numr_in/denr_in carry a valid pixel beat.
- numr_in  input  NUMR_WIDTH  16 signed numerator lanes, lane 0 in LSBs.
- denr_in  input  DENR_WIDTH  16 signed denominator lanes, lane 0 in LSBs.
- in_ready  output  1  block accepts beats (high only in ACCUM).
- out_valid  output  1  frame sums valid.
- out_ready  input  1  consumer takes the sums.
- numr_sum  output  ACC_WIDTH  signed frame numerator sum.
- denr_sum  output  ACC_WIDTH  signed frame denominator sum.
- beat_cnt  output  clog2(BEATS)  beats accepted in the current frame (debug).

Behaviour:
- BEATS = IMAGE_DIM*IMAGE_DIM/PIXELS_PER_BEAT, which is 16384 at defaults.
- Reset (aresetn=0 at a clk edge):
  - state=ACCUM; all registers cleared.
  - in_ready=1, out_valid=0, numr_sum=0, denr_sum=0, beat_cnt=0.
  - Reset mid-frame discards all partial state; the next accepted beat is beat 0 of a new frame.
- Accept condition: accept = in_valid & in_ready & ~stall. beat_cnt increments on accept and wraps to 0 after BEATS-1.
- Pipeline, with all stages gated by ~stall:
  - S1: register the lane sums. Each lane is sign-extended to ACC_WIDTH, then the 16 lanes are summed (adder tree). A valid bit travels with the data.
  - S2: accumulator, acc += S1 sum when the S1 valid bit is set.
  - A bubble (in_valid=0 or stall=1) never alters the accumulators.
- States:
  - ACCUM: in_ready=1. On accept of beat BEATS-1, go to DRAIN.
  - DRAIN: in_ready=0. Pipeline advances on ~stall. When the last beat's S2 update is done, copy the accumulators to numr_sum/denr_sum, clear the accumulators, set out_valid=1, go to HOLD.
    - Latency: last accept to out_valid = 2 unstalled cycles; stall cycles add 1:1.
  - HOLD: in_ready=0; out_valid=1; sums stable. `stall` is ignored. When out_valid & out_ready, go to ACCUM with in_ready=1 the next cycle; out_valid drops the same cycle.
    - out_ready already high on entry gives exactly a 1-cycle out_valid pulse.
- numr_sum/denr_sum hold their last value after handoff until the next frame overwrites them.
- Arithmetic:
  - Two's complement throughout.
  - Overflow beyond ACC_WIDTH wraps silently; no saturation.
  - Numerator and denominator paths are identical and independent.
- Boundary cases:
  - stall=1 in the same cycle as beat BEATS-1 with in_valid=1: the beat is not accepted and the state does not change.
  - in_valid held high while in_ready=0: the beat is dropped. Upstream must honour in_ready (assertion in bench).
  - out_ready high outside HOLD: ignored.

Test Plan:
- Defaults, all lanes numr=1, denr=2, every cycle, stall=0 -> after 16384 accepts and 2 cycles: out_valid=1, numr_sum=262144, denr_sum=524288, beat_cnt=0.
- All lanes numr=-1, denr=0x7_FFFF_FFFF (max positive 36-bit) -> numr_sum=-262144, denr_sum=262144*(2^35-1), no wrap at ACC_WIDTH=56.
- IMAGE_DIM=8, PPB=4 (16 beats), lane value = beat index, with stall pulsed 3 cycles at beats 5 and 15 and in_valid gaps -> numr_sum=4*120=480; out_valid is delayed exactly by the stall count; no double counting.
- Frame 1 completes with out_ready=0 for 10 cycles -> out_valid and the sums are stable, in_ready=0 throughout. Then out_ready=1 -> frame 2 (all lanes 3) sums to 3*262144 independently of frame 1.
- aresetn=0 for 1 cycle after 100 beats -> all outputs at reset values. A full following frame of ones yields exactly 262144, with no residue from the aborted frame.
- Alternating sign per lane (+5/-5) -> numr_sum=0, denr_sum=0; out_valid still asserts after BEATS beats.
